// File: rtl/ctrl_antitrepidacao.sv
// ctrl_antitrepidacao: debounces a bouncing input with a 2-flop synchroniser and stability counter,
// producing a filtered level, one-cycle edge pulses and a saturating count of rejected bounces.
module ctrl_antitrepidacao #(
    parameter int   N_ESTAVEL   = 16,
    parameter int   W_CNT       = 8,
    parameter int   W_TREP      = 8,
    parameter logic NIVEL_RESET = 1'b0
) (
    input  logic              clkIn,
    input  logic              clr,
    input  logic              entrada,
    input  logic              limpa_trep,
    output logic              saida,
    output logic              pulso_sub,
    output logic              pulso_desc,
    output logic              ocupado,
    output logic [W_TREP-1:0] n_trep
);
    typedef enum logic {ESTAVEL, CONTANDO} estado_t;
    localparam logic [W_CNT-1:0]  CNT_FIM  = W_CNT'(N_ESTAVEL - 1);
    localparam logic [W_TREP-1:0] TREP_MAX = '1;
    estado_t           r_estado, w_prox;
    logic              r_sinc1, r_sinc2, r_saida, r_sub, r_desc;
    logic              w_saida, w_sub, w_desc, w_aborta;
    logic [W_CNT-1:0]  r_cnt, w_cnt;
    logic [W_TREP-1:0] r_trep, w_trep;
    always_comb begin
        w_prox   = r_estado;
        w_cnt    = '0;
        w_saida  = r_saida;
        w_sub    = 1'b0;
        w_desc   = 1'b0;
        w_aborta = 1'b0;
        case (r_estado)
            ESTAVEL: w_prox = (r_sinc2 != r_saida) ? CONTANDO : ESTAVEL;
            CONTANDO: begin
                if (r_sinc2 == r_saida) begin
                    w_prox   = ESTAVEL;
                    w_aborta = 1'b1;
                end else if (r_cnt == CNT_FIM) begin
                    w_prox  = ESTAVEL;
                    w_saida = ~r_saida;
                    w_sub   = ~r_saida;
                    w_desc  = r_saida;
                end else begin
                    w_cnt = r_cnt + W_CNT'(1);
                end
            end
        endcase
        // clear wins over a same-cycle abort; the count sticks at all-ones
        w_trep = limpa_trep ? '0 : (w_aborta && r_trep != TREP_MAX) ? r_trep + W_TREP'(1) : r_trep;
    end
    always_ff @(posedge clkIn or negedge clr) begin
        if (!clr) begin
            r_sinc1  <= NIVEL_RESET;
            r_sinc2  <= NIVEL_RESET;
            r_saida  <= NIVEL_RESET;
            r_estado <= ESTAVEL;
            r_cnt    <= '0;
            r_trep   <= '0;
            r_sub    <= 1'b0;
            r_desc   <= 1'b0;
        end else begin
            r_sinc1  <= entrada;
            r_sinc2  <= r_sinc1;
            r_saida  <= w_saida;
            r_estado <= w_prox;
            r_cnt    <= w_cnt;
            r_trep   <= w_trep;
            r_sub    <= w_sub;
            r_desc   <= w_desc;
        end
    end
    assign saida      = r_saida;
    assign pulso_sub  = r_sub;
    assign pulso_desc = r_desc;
    assign ocupado    = (r_estado == CONTANDO);
    assign n_trep     = r_trep;
endmodule

// File: tb/tb_ctrl_antitrepidacao.sv
// tb_ctrl_antitrepidacao: directed checks of debounce latency, bounce rejection, pulses,
// bounce-counter clear/saturation and asynchronous reset.
module tb_ctrl_antitrepidacao;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       entrada = 1'b0;
    logic       limpa_trep = 1'b0;
    logic       saida, pulso_sub, pulso_desc, ocupado;
    logic [7:0] n_trep;
    int total = 0;
    int bad = 0;
    int c_ocup = 0;
    int c_sub = 0;
    int c_desc = 0;
    int c_rst = 0;
    ctrl_antitrepidacao dut (
        .clkIn(clk), .clr(clr), .entrada(entrada), .limpa_trep(limpa_trep),
        .saida(saida), .pulso_sub(pulso_sub), .pulso_desc(pulso_desc),
        .ocupado(ocupado), .n_trep(n_trep)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            c_ocup += int'(ocupado);
            c_sub  += int'(pulso_sub);
            c_desc += int'(pulso_desc);
            if (pulso_sub && pulso_desc) c_desc += 1000;
        end
    endtask
    task automatic clr_cnt();
        c_ocup = 0;
        c_sub  = 0;
        c_desc = 0;
    endtask
    initial begin
        for (int i = 0; i < 10; i++) begin
            entrada = ~entrada;
            run(1);
            if ({saida, pulso_sub, pulso_desc, ocupado, n_trep} != 12'd0) c_rst++;
        end
        chk("reset_hold", c_rst, 0);
        entrada = 1'b0;
        clr = 1'b1;
        clr_cnt();
        run(4);
        chk("release_no_pulse", {c_sub[15:0], c_desc[15:0]}, 0);
        chk("release_state", {saida, ocupado, n_trep}, 0);
        entrada = 1'b1;
        clr_cnt();
        run(18);
        chk("rise_before_commit", {saida, ocupado}, 2'b01);
        chk("rise_busy_cycles", c_ocup, 16);
        run(1);
        chk("rise_commit", {saida, pulso_sub, pulso_desc, ocupado}, 4'b1100);
        run(5);
        chk("rise_single_pulse", {c_sub[15:0], c_desc[15:0]}, {16'd1, 16'd0});
        chk("rise_ntrep", n_trep, 0);
        entrada = 1'b0;
        clr_cnt();
        run(18);
        chk("fall_before_commit", saida, 1);
        run(1);
        chk("fall_commit", {saida, pulso_sub, pulso_desc}, 3'b001);
        run(3);
        chk("fall_single_pulse", {c_sub[15:0], c_desc[15:0]}, {16'd0, 16'd1});
        clr_cnt();
        for (int g = 0; g < 3; g++) begin
            entrada = 1'b1;
            run(5);
            entrada = 1'b0;
            run(5);
        end
        chk("bounce_ntrep", n_trep, 3);
        chk("bounce_saida", saida, 0);
        entrada = 1'b1;
        run(18);
        chk("bounce_before_commit", saida, 0);
        run(1);
        chk("bounce_commit", {saida, pulso_sub}, 2'b11);
        run(2);
        chk("bounce_pulses", {c_sub[15:0], c_desc[15:0]}, {16'd1, 16'd0});
        entrada = 1'b0;
        run(3);
        chk("glitch_busy", ocupado, 1);
        entrada = 1'b1;
        run(2);
        limpa_trep = 1'b1;
        run(1);
        limpa_trep = 1'b0;
        chk("clear_beats_abort", {saida, ocupado, n_trep}, {2'b10, 8'd0});
        entrada = 1'b0;
        run(3);
        entrada = 1'b1;
        run(5);
        chk("abort_after_clear", n_trep, 1);
        entrada = 1'b0;
        run(20);
        chk("fall_again", saida, 0);
        limpa_trep = 1'b1;
        run(1);
        limpa_trep = 1'b0;
        clr_cnt();
        entrada = 1'b1;
        run(15);
        entrada = 1'b0;
        run(10);
        chk("short_glitch", {saida, n_trep}, {1'b0, 8'd1});
        chk("short_glitch_no_pulse", c_sub + c_desc, 0);
        clr_cnt();
        entrada = 1'b1;
        run(17);
        entrada = 1'b0;
        run(2);
        chk("min_width_commit", {saida, pulso_sub}, 2'b11);
        run(1);
        chk("toggle_at_commit_recount", {saida, ocupado}, 2'b11);
        run(16);
        chk("toggle_at_commit_fall", {saida, pulso_desc}, 2'b01);
        limpa_trep = 1'b1;
        for (int i = 0; i < 20; i++) begin
            entrada = ~entrada;
            run(1);
        end
        limpa_trep = 1'b0;
        chk("clear_held", n_trep, 0);
        clr_cnt();
        for (int i = 0; i < 600; i++) begin
            entrada = ~entrada;
            run(1);
        end
        chk("saturate", n_trep, 255);
        for (int i = 0; i < 40; i++) begin
            entrada = ~entrada;
            run(1);
        end
        entrada = 1'b0;
        run(5);
        chk("saturate_hold", {saida, n_trep}, {1'b0, 8'd255});
        chk("toggle_no_pulse", c_sub + c_desc, 0);
        entrada = 1'b1;
        run(13);
        chk("midcount_busy", ocupado, 1);
        clr = 1'b0;
        #1;
        chk("async_reset", {saida, pulso_sub, pulso_desc, ocupado, n_trep}, 0);
        clr_cnt();
        run(2);
        clr = 1'b1;
        run(18);
        chk("restart_before_commit", {saida, ocupado}, 2'b01);
        chk("restart_no_pulse", c_sub + c_desc, 0);
        run(1);
        chk("restart_commit", {saida, pulso_sub, n_trep}, {2'b11, 8'd0});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
